// File: rtl/frame_align_ctrl_pkg.sv
// Shared frame geometry, FAS pattern and aligner state encoding.
package frame_align_ctrl_pkg;

    localparam int unsigned NUM_ROWS     = 4;
    localparam int unsigned NUM_COLS     = 1041;
    localparam int unsigned OH_LAST      = 15;
    localparam int unsigned PL_FIRST     = 16;
    localparam int unsigned PL_LAST      = 1039;
    localparam int unsigned CRC_COL      = 1040;
    localparam int unsigned FAS_LAST_COL = 5;
    localparam logic [47:0] FAS_PATTERN  = 48'hF6F6F6282828;

    localparam int unsigned SYNC_CONFIRM = 2;
    localparam int unsigned LOSS_THRESH  = 4;

    localparam int unsigned ROW_W = 2;
    localparam int unsigned COL_W = 11;

    typedef enum logic [1:0] {
        StHunt    = 2'd0,
        StPresync = 2'd1,
        StSync    = 2'd2
    } align_state_e;

endpackage

// File: rtl/frame_align_ctrl_fas_detector.sv
// Six-byte window over valid line bytes; flags when the window including the
// current byte equals the FAS pattern.
module frame_align_ctrl_fas_detector
    import frame_align_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_match
);

    logic [47:0] sr_q, sr_d;

    // Shift in only qualified bytes.
    always_comb begin
        sr_d = sr_q;
        if (i_valid) begin
            sr_d = {sr_q[39:0], i_data};
        end
    end

    // Window register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Match is reported on the byte that completes the pattern.
    assign o_match = i_valid && (sr_d == FAS_PATTERN);

endmodule

// File: rtl/frame_align_ctrl.sv
// Frame aligner: hunt/presync/sync lock FSM, row/column tracking, registered
// aligned-byte output and saturating CRC error accounting.
module frame_align_ctrl
    import frame_align_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_COLS = NUM_COLS,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_data_valid,
    output logic [7:0]           o_frame_data,
    output logic                 o_frame_data_valid,
    output logic                 o_frame_data_fas,
    output logic [ROW_W-1:0]     o_row_cnt,
    output logic [COL_W-1:0]     o_col_cnt,
    input  logic                 i_crc_err,
    input  logic                 i_crc_err_valid,
    input  logic                 i_err_cnt_clr,
    output logic                 o_in_frame,
    output logic                 o_lof,
    output logic [ERR_CNT_W-1:0] o_crc_err_cnt
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(FRAME_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] FAS_COL  = COL_W'(FAS_LAST_COL);
    localparam logic [2:0]       CONFIRM  = 3'(SYNC_CONFIRM);
    localparam logic [2:0]       LOSS     = 3'(LOSS_THRESH);
    // Loaded on the edge that registers row 3 / last col; expires two clocks
    // after that byte is presented.
    localparam logic [1:0]       CRC_LOAD = 2'd3;

    align_state_e         state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [2:0]           match_cnt_q, match_cnt_d;
    logic [2:0]           miss_cnt_q, miss_cnt_d;
    logic [2:0]           miss_next;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fas_q, fas_d;
    logic [ROW_W-1:0]     orow_q, orow_d;
    logic [COL_W-1:0]     ocol_q, ocol_d;
    logic [1:0]           timer_q, timer_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 fas_match;
    logic                 at_fas_check;
    logic                 err_inc;

    frame_align_ctrl_fas_detector u_fas_detector (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_rx_data),
        .i_valid (i_rx_data_valid),
        .o_match (fas_match)
    );

    assign at_fas_check = (row_q == '0) && (col_q == FAS_COL);
    assign miss_next    = miss_cnt_q + 3'd1;

    // Lock FSM and position counters; everything holds on invalid cycles.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (i_rx_data_valid) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            unique case (state_q)
                StHunt: begin
                    row_d = '0;
                    col_d = '0;
                    if (fas_match) begin
                        state_d     = StPresync;
                        match_cnt_d = 3'd1;
                        col_d       = FAS_COL + 1'b1;
                    end
                end
                StPresync: begin
                    if (at_fas_check) begin
                        if (fas_match) begin
                            match_cnt_d = match_cnt_q + 3'd1;
                            if (match_cnt_q + 3'd1 == CONFIRM) begin
                                state_d    = StSync;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            state_d     = StHunt;
                            match_cnt_d = '0;
                            row_d       = '0;
                            col_d       = '0;
                        end
                    end
                end
                StSync: begin
                    if (at_fas_check) begin
                        if (fas_match) begin
                            miss_cnt_d = '0;
                        end else if (miss_next == LOSS) begin
                            state_d     = StHunt;
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                            row_d       = '0;
                            col_d       = '0;
                        end else begin
                            miss_cnt_d = miss_next;
                        end
                    end
                end
                default: begin
                    state_d = StHunt;
                end
            endcase
        end
    end

    // Output stage, CRC sample timer and error counter next state.
    always_comb begin
        data_d  = data_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        valid_d = i_rx_data_valid && (state_q == StSync);
        fas_d   = valid_d && (row_q == '0) && (col_q <= FAS_COL);
        if (i_rx_data_valid) begin
            data_d = i_rx_data;
            orow_d = row_q;
            ocol_d = col_q;
        end

        timer_d = (timer_q != '0) ? timer_q - 2'd1 : timer_q;
        if (valid_d && (row_q == LAST_ROW) && (col_q == LAST_COL)) begin
            timer_d = CRC_LOAD;
        end
        if (state_d != StSync) begin
            timer_d = '0;
        end

        err_inc   = (timer_q == 2'd1) && (state_q == StSync) && i_crc_err_valid && i_crc_err;
        err_cnt_d = err_cnt_q;
        if (i_err_cnt_clr) begin
            err_cnt_d = err_inc ? ERR_CNT_W'(1) : '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StHunt;
            row_q       <= '0;
            col_q       <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            fas_q       <= 1'b0;
            orow_q      <= '0;
            ocol_q      <= '0;
            timer_q     <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            fas_q       <= fas_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            timer_q     <= timer_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_frame_data       = data_q;
    assign o_frame_data_valid = valid_q;
    assign o_frame_data_fas   = fas_q;
    assign o_row_cnt          = orow_q;
    assign o_col_cnt          = ocol_q;
    assign o_in_frame         = (state_q == StSync);
    assign o_lof              = (state_q != StSync);
    assign o_crc_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_frame_align_ctrl.sv
// Scoreboard bench for frame_align_ctrl using a shortened row length.
module tb_frame_align_ctrl;
    import frame_align_ctrl_pkg::*;

    localparam int COLS = 40;
    localparam int CW   = 4;
    localparam int FLEN = COLS * int'(NUM_ROWS);

    typedef struct packed {
        logic [7:0]  data;
        logic [1:0]  row;
        logic [10:0] col;
        logic        fas;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    i_rx_data;
    logic          i_rx_data_valid;
    logic [7:0]    o_frame_data;
    logic          o_frame_data_valid;
    logic          o_frame_data_fas;
    logic [1:0]    o_row_cnt;
    logic [10:0]   o_col_cnt;
    logic          i_crc_err;
    logic          i_crc_err_valid;
    logic          i_err_cnt_clr;
    logic          o_in_frame;
    logic          o_lof;
    logic [CW-1:0] o_crc_err_cnt;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] stim[$];
    logic [7:0] saved[$];
    exp_t       sb[$];
    int         crc_plan[$];
    int         exp_cnt = 0;
    bit         exp_sync_end;

    frame_align_ctrl #(
        .FRAME_COLS (COLS),
        .ERR_CNT_W  (CW)
    ) u_dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_rx_data          (i_rx_data),
        .i_rx_data_valid    (i_rx_data_valid),
        .o_frame_data       (o_frame_data),
        .o_frame_data_valid (o_frame_data_valid),
        .o_frame_data_fas   (o_frame_data_fas),
        .o_row_cnt          (o_row_cnt),
        .o_col_cnt          (o_col_cnt),
        .i_crc_err          (i_crc_err),
        .i_crc_err_valid    (i_crc_err_valid),
        .i_err_cnt_clr      (i_err_cnt_clr),
        .o_in_frame         (o_in_frame),
        .o_lof              (o_lof),
        .o_crc_err_cnt      (o_crc_err_cnt)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic void add_random(input int n);
        for (int k = 0; k < n; k++) stim.push_back(8'($urandom));
    endfunction

    function automatic void add_frame(input bit bad);
        logic [47:0] fas;
        logic [7:0]  b;
        fas = FAS_PATTERN;
        for (int p = 0; p < FLEN; p++) begin
            b = (p < 6) ? fas[47 - 8 * p -: 8] : 8'($urandom);
            if (bad && p == 3) b = b ^ 8'h5A;
            stim.push_back(b);
        end
    endfunction

    function automatic bit win_match(input int i, input int n);
        logic [47:0] w;
        w = '0;
        if (i < 5 || i >= n) return 1'b0;
        for (int q = 0; q < 6; q++) w = {w[39:0], stim[i - 5 + q]};
        return w == FAS_PATTERN;
    endfunction

    // Reference: locate frames in the byte index space and list the aligned
    // bytes that must appear on the output, in order.
    function automatic void model(input int n);
        int   i, anchor, j, k, miss, last, sync_at, pos;
        bit   ok;
        exp_t e;
        i = 0;
        exp_sync_end = 1'b0;
        while (i < n) begin
            while (i < n && !win_match(i, n)) i++;
            if (i >= n) break;
            anchor = i - 5;
            exp_sync_end = 1'b0;
            ok = 1'b1;
            for (k = 1; k < int'(SYNC_CONFIRM); k++) begin
                j = anchor + k * FLEN + 5;
                if (j >= n) begin ok = 1'b0; i = n; break; end
                if (!win_match(j, n)) begin ok = 1'b0; i = j + 1; break; end
            end
            if (!ok) continue;
            sync_at = anchor + (int'(SYNC_CONFIRM) - 1) * FLEN + 5;
            last = n - 1;
            miss = 0;
            exp_sync_end = 1'b1;
            for (k = int'(SYNC_CONFIRM); anchor + k * FLEN + 5 < n; k++) begin
                j = anchor + k * FLEN + 5;
                if (win_match(j, n)) begin
                    miss = 0;
                end else begin
                    miss++;
                    if (miss == int'(LOSS_THRESH)) begin
                        last = j;
                        exp_sync_end = 1'b0;
                        break;
                    end
                end
            end
            for (int b = sync_at + 1; b <= last; b++) begin
                pos    = b - anchor;
                e.data = stim[b];
                e.col  = 11'(pos % COLS);
                e.row  = 2'((pos / COLS) % int'(NUM_ROWS));
                e.fas  = (e.row == 2'd0) && (e.col <= 11'd5);
                sb.push_back(e);
            end
            i = last + 1;
        end
    endfunction

    task automatic run_stream(input int n_send, input bit gaps);
        for (int k = 0; k < n_send; k++) begin
            if (gaps) begin
                while ($urandom_range(1, 0) == 1) begin
                    @(negedge clk);
                    i_rx_data       = 8'($urandom);
                    i_rx_data_valid = 1'b0;
                end
            end
            @(negedge clk);
            i_rx_data       = stim[k];
            i_rx_data_valid = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        i_rx_data_valid = 1'b0;
        i_crc_err       = 1'b0;
        i_crc_err_valid = 1'b0;
        i_err_cnt_clr   = 1'b0;
        sb.delete();
        crc_plan.delete();
        stim.delete();
        exp_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic end_phase(input string name);
        @(negedge clk);
        i_rx_data_valid = 1'b0;
        repeat (12) @(negedge clk);
        check({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
        check({name, "_in_frame"}, 32'(o_in_frame), 32'(exp_sync_end));
        check({name, "_lof"}, 32'(o_lof), 32'(!exp_sync_end));
    endtask

    // Monitor: every presented output must be the next expected aligned byte.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_frame_data_valid === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL frame_out: got row %0d col %0d data %h, required no output",
                             o_row_cnt, o_col_cnt, o_frame_data);
                end else begin
                    e = sb.pop_front();
                    if ({o_frame_data, o_row_cnt, o_col_cnt, o_frame_data_fas} !== e) begin
                        n_err++;
                        $display("FAIL frame_out: got data %h row %0d col %0d fas %0b, required data %h row %0d col %0d fas %0b",
                                 o_frame_data, o_row_cnt, o_col_cnt, o_frame_data_fas,
                                 e.data, e.row, e.col, e.fas);
                    end
                end
            end
        end
    end

    // crc_calc stand-in: mode 1 reports an error in the sample slot, mode 2
    // holds the error high everywhere except the sample slot, mode 3 reports
    // an error together with a counter clear.
    initial begin
        int mode;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_frame_data_valid === 1'b1 && o_row_cnt == 2'(NUM_ROWS - 1)
                && o_col_cnt == 11'(COLS - 1) && crc_plan.size() != 0) begin
                mode            = crc_plan.pop_front();
                i_crc_err_valid = 1'b1;
                i_crc_err       = (mode == 2);
                @(posedge clk);
                @(posedge clk);
                #1;
                i_crc_err     = (mode != 2);
                i_err_cnt_clr = (mode == 3);
                @(posedge clk);
                #1;
                i_crc_err     = (mode == 2);
                i_err_cnt_clr = 1'b0;
                if (mode == 1) exp_cnt = (exp_cnt == (1 << CW) - 1) ? exp_cnt : exp_cnt + 1;
                if (mode == 3) exp_cnt = 1;
                @(negedge clk);
                check("crc_err_cnt", 32'(o_crc_err_cnt), 32'(exp_cnt));
                repeat (2) @(posedge clk);
                #1;
                i_crc_err = 1'b0;
            end
        end
    end

    initial begin
        int n_send;
        rst_n           = 1'b0;
        i_rx_data       = '0;
        i_rx_data_valid = 1'b0;
        i_crc_err       = 1'b0;
        i_crc_err_valid = 1'b0;
        i_err_cnt_clr   = 1'b0;

        // Lock from random line noise.
        do_reset();
        check("reset_lof", 32'(o_lof), 32'd1);
        check("reset_in_frame", 32'(o_in_frame), 32'd0);
        add_random(137);
        for (int f = 0; f < 5; f++) add_frame(1'b0);
        saved = stim;
        model(stim.size());
        run_stream(stim.size(), 1'b0);
        end_phase("lock");

        // Same stream with random idle gaps.
        do_reset();
        stim = saved;
        model(stim.size());
        run_stream(stim.size(), 1'b1);
        end_phase("gaps");

        // Four consecutive FAS misses drop lock.
        do_reset();
        add_random(137);
        for (int f = 0; f < 4; f++) add_frame(1'b0);
        for (int f = 0; f < 4; f++) add_frame(1'b1);
        add_frame(1'b0);
        model(stim.size());
        run_stream(stim.size(), 1'b0);
        end_phase("loss");

        // Three misses then a good FAS keep lock.
        do_reset();
        add_random(137);
        for (int f = 0; f < 3; f++) add_frame(1'b0);
        for (int f = 0; f < 3; f++) add_frame(1'b1);
        for (int f = 0; f < 2; f++) add_frame(1'b0);
        model(stim.size());
        run_stream(stim.size(), 1'b0);
        end_phase("hold");

        // CRC accounting, off-slot errors, saturation, clear-with-increment.
        do_reset();
        add_random(137);
        for (int f = 0; f < 23; f++) add_frame(1'b0);
        crc_plan.push_back(1);
        crc_plan.push_back(2);
        for (int k = 0; k < 18; k++) crc_plan.push_back(1);
        crc_plan.push_back(3);
        crc_plan.push_back(2);
        model(stim.size());
        run_stream(stim.size(), 1'b0);
        end_phase("crc");
        check("crc_plan_drained", 32'(crc_plan.size()), 32'd0);

        // Asynchronous reset in the middle of a locked frame.
        do_reset();
        add_random(137);
        for (int f = 0; f < 3; f++) add_frame(1'b0);
        crc_plan.push_back(1);
        n_send = 137 + 2 * FLEN + 70;
        model(n_send - 1);
        run_stream(n_send, 1'b0);
        @(posedge clk);
        #2;
        check("pre_reset_valid", 32'(o_frame_data_valid), 32'(exp_sync_end));
        check("pre_reset_cnt", 32'(o_crc_err_cnt), 32'(exp_cnt));
        rst_n = 1'b0;
        #1;
        check("async_lof", 32'(o_lof), 32'd1);
        check("async_in_frame", 32'(o_in_frame), 32'd0);
        check("async_valid", 32'(o_frame_data_valid), 32'd0);
        check("async_fas", 32'(o_frame_data_fas), 32'd0);
        check("async_data", 32'(o_frame_data), 32'd0);
        check("async_row_col", {19'd0, o_row_cnt, o_col_cnt}, 32'd0);
        check("async_cnt", 32'(o_crc_err_cnt), 32'd0);
        i_rx_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("async_sb_drained", 32'(sb.size()), 32'd0);
        check("async_lof_after", 32'(o_lof), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
